// File: rtl/reg_bank_ctrl_if.sv
// Write and read-back bus of reg_bank_ctrl.
// Signal directions are named from the register bank's point of view.
interface reg_bank_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3,
    parameter int LW = 4
);
    logic          i_wr_vld;
    logic          o_wr_rdy;
    logic          i_wr_bank;
    logic [AW-1:0] i_wr_addr;
    logic [LW-1:0] i_wr_len;
    logic [DW-1:0] i_wr_data;
    logic          o_wr_err;
    logic          i_rd_vld;
    logic          i_rd_bank;
    logic [AW-1:0] i_rd_addr;
    logic          o_rd_vld;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_err;

    modport slave (
        input  i_wr_vld, i_wr_bank, i_wr_addr, i_wr_len, i_wr_data,
        input  i_rd_vld, i_rd_bank, i_rd_addr,
        output o_wr_rdy, o_wr_err, o_rd_vld, o_rd_data, o_rd_err
    );

    modport master (
        output i_wr_vld, i_wr_bank, i_wr_addr, i_wr_len, i_wr_data,
        output i_rd_vld, i_rd_bank, i_rd_addr,
        input  o_wr_rdy, o_wr_err, o_rd_vld, o_rd_data, o_rd_err
    );
endinterface

// File: rtl/reg_bank_ctrl.sv
// Two parametrised register banks with burst write port, read-back and snapshot.
// Optional per-register parity checking: define REG_BANK_CTRL_PARITY_EN.
module reg_bank_ctrl #(
    parameter int DW    = 8,
    parameter int NUM_A = 5,
    parameter int NUM_B = 3,
    parameter int NCH   = 3,
    parameter int LW    = 4,
    localparam int NMAX = (NUM_A > NUM_B) ? NUM_A : NUM_B,
    localparam int AW   = (NMAX > 1) ? $clog2(NMAX) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_lock,
    reg_bank_ctrl_if.slave                bus,
    input  logic                          i_cap_en,
    input  logic [0:NCH-1][DW-1:0]        i_sig_c,
    output logic [0:NCH-1][DW-1:0]        o_sig_g,
`ifdef REG_BANK_CTRL_PARITY_EN
    output logic                          o_par_err,
`endif
    output logic [0:NUM_A-1][DW-1:0]      o_reg_a,
    output logic [0:NUM_B-1][DW-1:0]      o_reg_b
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]    state_q;
    logic          bank_q;
    logic          oor_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] cnt_q;
    logic          rdy_q;
    logic          wr_err_q;
    logic          rd_vld_q;
    logic          rd_err_q;
    logic [DW-1:0] rd_data_q;

    logic          idle;
    logic          accept;
    logic          cur_bank;
    logic [AW-1:0] cur_addr;
    logic [AW-1:0] nxt_addr;
    logic          in_range;
    logic          wr_en;
    int            lim;
    logic          rd_in_range;
    logic [DW-1:0] rd_mux;

    // In BURST the beat's own bank/address fields are ignored.
    always_comb begin
        idle     = (state_q == IDLE);
        accept   = bus.i_wr_vld && rdy_q;
        cur_bank = idle ? bus.i_wr_bank : bank_q;
        cur_addr = idle ? bus.i_wr_addr : addr_q;
        lim      = cur_bank ? NUM_B : NUM_A;
        in_range = 32'(cur_addr) < lim;
        wr_en    = accept && (idle ? in_range : !oor_q);
        nxt_addr = (32'(cur_addr) >= lim - 1) ? '0 : cur_addr + AW'(1);
    end

    always_comb begin
        rd_in_range = bus.i_rd_bank ? (32'(bus.i_rd_addr) < NUM_B)
                                    : (32'(bus.i_rd_addr) < NUM_A);
        rd_mux = '0;
        for (int i = 0; i < NUM_A; i++)
            if (!bus.i_rd_bank && 32'(bus.i_rd_addr) == i)
                rd_mux = o_reg_a[i];
        for (int i = 0; i < NUM_B; i++)
            if (bus.i_rd_bank && 32'(bus.i_rd_addr) == i)
                rd_mux = o_reg_b[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            bank_q   <= 1'b0;
            oor_q    <= 1'b0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rdy_q    <= !i_lock;
            wr_err_q <= accept && idle && !in_range;
            if (accept) begin
                addr_q <= nxt_addr;
                unique case (1'b1)
                    idle: begin
                        bank_q <= bus.i_wr_bank;
                        oor_q  <= !in_range;
                        cnt_q  <= bus.i_wr_len;
                        if (bus.i_wr_len != '0)
                            state_q <= BURST;
                    end
                    default: begin
                        cnt_q <= cnt_q - LW'(1);
                        if (cnt_q == LW'(1))
                            state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_reg_a <= '0;
            o_reg_b <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_A; i++)
                if (!cur_bank && 32'(cur_addr) == i)
                    o_reg_a[i] <= bus.i_wr_data;
            for (int i = 0; i < NUM_B; i++)
                if (cur_bank && 32'(cur_addr) == i)
                    o_reg_b[i] <= bus.i_wr_data;
        end
    end

    // Read samples pre-edge bank contents, so a same-cycle write is not seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            o_sig_g   <= '0;
        end else begin
            rd_vld_q <= bus.i_rd_vld;
            rd_err_q <= bus.i_rd_vld && !rd_in_range;
            if (bus.i_rd_vld)
                rd_data_q <= rd_mux;
            if (i_cap_en)
                o_sig_g <= i_sig_c;
        end
    end

`ifdef REG_BANK_CTRL_PARITY_EN
    logic [NUM_A-1:0] par_a;
    logic [NUM_B-1:0] par_b;
    logic             par_bad;

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NUM_A; i++)
            if (!bus.i_rd_bank && 32'(bus.i_rd_addr) == i)
                par_bad = (^o_reg_a[i]) != par_a[i];
        for (int i = 0; i < NUM_B; i++)
            if (bus.i_rd_bank && 32'(bus.i_rd_addr) == i)
                par_bad = (^o_reg_b[i]) != par_b[i];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            par_a     <= '0;
            par_b     <= '0;
            o_par_err <= 1'b0;
        end else begin
            if (wr_en) begin
                for (int i = 0; i < NUM_A; i++)
                    if (!cur_bank && 32'(cur_addr) == i)
                        par_a[i] <= ^bus.i_wr_data;
                for (int i = 0; i < NUM_B; i++)
                    if (cur_bank && 32'(cur_addr) == i)
                        par_b[i] <= ^bus.i_wr_data;
            end
            if (bus.i_rd_vld && rd_in_range && par_bad)
                o_par_err <= 1'b1;
        end
    end
`endif

    assign bus.o_wr_rdy  = rdy_q;
    assign bus.o_wr_err  = wr_err_q;
    assign bus.o_rd_vld  = rd_vld_q;
    assign bus.o_rd_err  = rd_err_q;
    assign bus.o_rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Directed bench for reg_bank_ctrl: vector table plus lock, snapshot
// and mid-burst reset sequences.
module tb_reg_bank_ctrl;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic lock;
    logic cap_en;
    logic [0:2][7:0] sig_c;
    logic [0:2][7:0] sig_g;
    logic [0:4][7:0] reg_a;
    logic [0:2][7:0] reg_b;
`ifdef REG_BANK_CTRL_PARITY_EN
    logic par_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    reg_bank_ctrl_if #(.DW(DW), .AW(AW), .LW(LW)) bus ();

    reg_bank_ctrl dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_lock   (lock),
        .bus      (bus),
        .i_cap_en (cap_en),
        .i_sig_c  (sig_c),
        .o_sig_g  (sig_g),
`ifdef REG_BANK_CTRL_PARITY_EN
        .o_par_err(par_err),
`endif
        .o_reg_a  (reg_a),
        .o_reg_b  (reg_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic          bank;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] data;
        logic          rd;
        logic          rbank;
        logic [AW-1:0] raddr;
        logic          e_err;
        logic          e_rvld;
        logic [DW-1:0] e_rdata;
        logic          e_rerr;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic v, input logic b, input logic [AW-1:0] a,
                      input logic [LW-1:0] l, input logic [DW-1:0] d);
        bus.i_wr_vld  = v;
        bus.i_wr_bank = b;
        bus.i_wr_addr = a;
        bus.i_wr_len  = l;
        bus.i_wr_data = d;
    endtask

    initial begin
        vec[0]  = '{1, 0, 2, 0, 8'h5A, 0, 0, 0, 0, 0, 8'h00, 0};
        vec[1]  = '{0, 0, 0, 0, 8'h00, 1, 0, 2, 0, 1, 8'h5A, 0};
        vec[2]  = '{1, 0, 3, 3, 8'h11, 0, 0, 0, 0, 0, 8'h5A, 0};
        vec[3]  = '{1, 1, 0, 0, 8'h22, 1, 0, 3, 0, 1, 8'h11, 0};
        vec[4]  = '{1, 0, 0, 0, 8'h33, 1, 0, 0, 0, 1, 8'h00, 0};
        vec[5]  = '{1, 0, 0, 0, 8'h44, 1, 0, 0, 0, 1, 8'h33, 0};
        vec[6]  = '{0, 0, 0, 0, 8'h00, 1, 0, 1, 0, 1, 8'h44, 0};
        vec[7]  = '{1, 1, 5, 1, 8'h77, 0, 0, 0, 1, 0, 8'h44, 0};
        vec[8]  = '{1, 0, 0, 0, 8'h88, 0, 0, 0, 0, 0, 8'h44, 0};
        vec[9]  = '{0, 0, 0, 0, 8'h00, 1, 1, 5, 0, 1, 8'h00, 1};
        vec[10] = '{1, 1, 2, 0, 8'h99, 1, 1, 0, 0, 1, 8'h00, 0};
        vec[11] = '{0, 0, 0, 0, 8'h00, 1, 1, 2, 0, 1, 8'h99, 0};

        rst_n = 1'b0;
        lock = 1'b0;
        cap_en = 1'b0;
        sig_c = '0;
        wr(0, 0, 0, 0, 0);
        bus.i_rd_vld = 1'b0;
        bus.i_rd_bank = 1'b0;
        bus.i_rd_addr = '0;

        #12;
        chk("rst_reg_a", reg_a, 0);
        chk("rst_reg_b", reg_b, 0);
        chk("rst_sig_g", sig_g, 0);
        chk("rst_rd_data", bus.o_rd_data, 0);
        chk("rst_flags", {bus.o_wr_rdy, bus.o_wr_err,
                          bus.o_rd_vld, bus.o_rd_err}, 0);

        #5 rst_n = 1'b1;
        chk("rdy_first_cycle", bus.o_wr_rdy, 0);
        step();
        chk("rdy_second_cycle", bus.o_wr_rdy, 1);

        for (int i = 0; i < 12; i++) begin
            wr(vec[i].vld, vec[i].bank, vec[i].addr, vec[i].len, vec[i].data);
            bus.i_rd_vld  = vec[i].rd;
            bus.i_rd_bank = vec[i].rbank;
            bus.i_rd_addr = vec[i].raddr;
            step();
            chk($sformatf("v%0d_wr_rdy", i), bus.o_wr_rdy, 1);
            chk($sformatf("v%0d_wr_err", i), bus.o_wr_err, vec[i].e_err);
            chk($sformatf("v%0d_rd_vld", i), bus.o_rd_vld, vec[i].e_rvld);
            chk($sformatf("v%0d_rd_data", i), bus.o_rd_data, vec[i].e_rdata);
            chk($sformatf("v%0d_rd_err", i), bus.o_rd_err, vec[i].e_rerr);
        end
        wr(0, 0, 0, 0, 0);
        bus.i_rd_vld = 1'b0;
        step();
        chk("bank_a_after_table", reg_a, {8'h33, 8'h44, 8'h5A, 8'h11, 8'h22});
        chk("bank_b_after_table", reg_b, {8'h00, 8'h00, 8'h99});

        // Lock stall in the middle of a 3-beat burst to B starting at 1.
        wr(1, 1, 1, 2, 8'hD1);
        step();
        chk("lock_rdy0", bus.o_wr_rdy, 1);
        wr(0, 0, 0, 0, 0);
        lock = 1'b1;
        step();
        chk("lock_rdy1", bus.o_wr_rdy, 0);
        wr(1, 0, 0, 0, 8'hD2);
        step();
        chk("lock_rdy2", bus.o_wr_rdy, 0);
        chk("lock_no_write", reg_b, {8'h00, 8'hD1, 8'h99});
        step();
        chk("lock_rdy3", bus.o_wr_rdy, 0);
        lock = 1'b0;
        step();
        chk("lock_rdy4", bus.o_wr_rdy, 1);
        chk("lock_still_no_write", reg_b, {8'h00, 8'hD1, 8'h99});
        step();
        wr(1, 0, 0, 0, 8'hD3);
        step();
        wr(0, 0, 0, 0, 0);
        step();
        chk("lock_burst_done", reg_b, {8'hD3, 8'hD1, 8'hD2});
        wr(1, 1, 1, 0, 8'hE7);
        step();
        wr(0, 0, 0, 0, 0);
        step();
        chk("lock_back_idle", reg_b, {8'hD3, 8'hE7, 8'hD2});

        cap_en = 1'b1;
        sig_c = {8'hAA, 8'hBB, 8'hCC};
        step();
        cap_en = 1'b0;
        sig_c = {8'h11, 8'h22, 8'h33};
        step();
        step();
        chk("snapshot_hold", sig_g, {8'hAA, 8'hBB, 8'hCC});

        // Reset lands in the middle of a 6-beat burst.
        wr(1, 0, 0, 5, 8'hE0);
        step();
        wr(1, 0, 0, 0, 8'hE1);
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_reg_a", reg_a, 0);
        chk("midrst_reg_b", reg_b, 0);
        chk("midrst_sig_g", sig_g, 0);
        chk("midrst_rdy", bus.o_wr_rdy, 0);
        wr(0, 0, 0, 0, 0);
        #1 rst_n = 1'b1;
        step();
        chk("midrst_rdy_back", bus.o_wr_rdy, 1);
        wr(1, 0, 3, 0, 8'h63);
        step();
        wr(1, 1, 0, 0, 8'h50);
        step();
        wr(0, 0, 0, 0, 0);
        step();
        chk("midrst_idle_a", reg_a, {8'h00, 8'h00, 8'h00, 8'h63, 8'h00});
        chk("midrst_idle_b", reg_b, {8'h50, 8'h00, 8'h00});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
